color_round_ctrl: RTL
=====================

Name: color_round_ctrl

Overview:
Sequences one game round of the colour-match mechanic. On request it draws a non-black ball colour and three non-black decoy platform colours from an internal LFSR, then places the ball colour on one of four platform slots chosen at random. It presents the colour set to the renderer and judges the landing: hit or miss, saturating score, streak. It sits between the game FSM (start/landing events) and the VGA draw logic (colour buses).

Parameters:
LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1.
MAX_DRAWS, 4, consecutive rejected draws (1..15) before the fallback colour is forced.
SCORE_W, 8, score counter width.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start_round  in  1  pulse; request a new colour set
landed  in  1  pulse; ball has landed
landed_plat  in  2  platform index (0..3) sampled with landed
busy  out  1  high in GEN and PLACE
colors_valid  out  1  high in READY; colour buses stable
ball_color  out  3  ball colour
plat_colors  out  12  slot i = bits [3i+2:3i]
hit  out  1  one-cycle pulse: landed colour == ball colour
miss  out  1  one-cycle pulse: landed colour != ball colour
score  out  SCORE_W  saturating hit count
streak  out  4  consecutive hits, saturating at 15; cleared on miss

Behaviour:
- Reset values: state IDLE; lfsr = seed; busy, colors_valid, hit, miss = 0; ball_color = 0; plat_colors = 0; score = 0; streak = 0; reject counter = 0. Reset mid-round aborts the round with no hit/miss pulse.
- LFSR: 16-bit Galois. next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 0). Advances exactly once per cycle, and only in GEN and PLACE.
- States: IDLE, GEN, PLACE, READY.
- IDLE: start_round -> GEN on the next cycle. Draw index cleared.
- GEN: one draw per cycle, d = lfsr[2:0]. Fill order: ball, decoy1, decoy2, decoy3.
  - Accept d if it is nonzero. For decoys, d must also differ from the ball.
  - On reject, increment the reject counter. If the counter reaches MAX_DRAWS, force the fallback in that same cycle:
    - ball fallback = 3'd7;
    - decoy fallback = (ball % 7) + 1.
  - The reject counter clears on every accept or fallback.
  - After decoy3 is filled -> PLACE.
- PLACE (1 cycle): pos = lfsr[1:0].
  - Slot pos = ball colour.
  - Decoys 1, 2, 3 fill the remaining slots in ascending slot order.
  - Register ball_color and plat_colors, then -> READY.
- READY: colors_valid = 1 and the buses are held.
  - landed -> compare plat_colors slot[landed_plat] with ball_color.
  - Next cycle: pulse hit or miss for one cycle and update score/streak in that same cycle.
  - Then -> IDLE. colors_valid drops; the buses keep their last values.
- start_round outside IDLE is ignored. landed outside READY is ignored.
- start_round and landed arriving in the same cycle in READY: landed wins and start_round is dropped.
- Score saturates at 2^SCORE_W-1. Streak saturates at 15.
- Minimum latency from start_round to colors_valid: 6 cycles (4 GEN + 1 PLACE + entry).

Optional Feature:
DISTINCT_DECOYS_EN
- Defined: a decoy is also rejected if it equals an earlier decoy. The decoy fallback becomes the smallest c in the sequence ball%7+1, then (c%7)+1, … that is unused by the ball and by earlier decoys. All four slots are then distinct.
- Undefined: decoys may repeat each other and are only required to differ from the ball.

Test Plan:
- Seed 16'h0008, MAX_DRAWS=1, start_round one cycle after reset falls -> busy for 5 cycles, then colors_valid, ball_color=3'd7 (fallback), plat_colors=12'h2A7.
- Same setup, landed=1 with landed_plat=0 -> hit pulses once, score=1, streak=1, state IDLE, colors_valid=0.
- Same setup, landed_plat=2 (colour 2 ≠ 7) -> miss pulses once, score unchanged, streak=0.
- Default seed, 1000 rounds with random landings -> every ball and slot colour is nonzero, exactly one slot equals the ball, and hit/miss count matches the model. With DISTINCT_DECOYS_EN, all slots are pairwise distinct.
- start_round while busy, and landed while in GEN -> both ignored, no pulses, colour sequence identical to an undisturbed run.
- Preload score=2^SCORE_W-1 and streak=15 by hitting repeatedly, then one more hit -> both hold. Assert reset mid-GEN -> all outputs reach reset values next cycle and the following round reproduces the post-reset sequence.

Source files
------------

// File: rtl/color_round_ctrl_if.sv
// color_round_ctrl_if: bundles the game-FSM handshake and the renderer colour
// buses of the colour-match round controller.
// master = game FSM / renderer side, slave = color_round_ctrl.
interface color_round_ctrl_if #(
  parameter int SCORE_W = 8
);
  logic               start_round;
  logic               landed;
  logic [1:0]         landed_plat;
  logic               busy;
  logic               colors_valid;
  logic [2:0]         ball_color;
  logic [11:0]        plat_colors;
  logic               hit;
  logic               miss;
  logic [SCORE_W-1:0] score;
  logic [3:0]         streak;

  modport master (
    output start_round, landed, landed_plat,
    input  busy, colors_valid, ball_color, plat_colors, hit, miss, score, streak
  );

  modport slave (
    input  start_round, landed, landed_plat,
    output busy, colors_valid, ball_color, plat_colors, hit, miss, score, streak
  );
endinterface

// File: rtl/color_round_ctrl.sv
// color_round_ctrl: sequences one round of the colour-match mechanic.
// A 16-bit Galois LFSR supplies a non-black ball colour and three non-black
// decoys (one draw per cycle), the ball is dropped onto a random slot, and the
// landing is judged as hit or miss with a saturating score and streak.
// Optional build macro DISTINCT_DECOYS_EN: decoys must also differ from each
// other, so all four platform slots end up pairwise distinct.
module color_round_ctrl #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_DRAWS = 4,
  parameter int          SCORE_W   = 8
) (
  input logic               clk,
  input logic               reset,
  color_round_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GEN   = 2'd1;
  localparam logic [1:0] S_PLACE = 2'd2;
  localparam logic [1:0] S_READY = 2'd3;

  // A zero seed would freeze the LFSR at zero, so it is swapped for the default.
  localparam logic [15:0]        SEED_EFF    = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [3:0]         MAX_DRAWS_C = 4'(MAX_DRAWS);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = {SCORE_W{1'b1}};

  logic [1:0]         state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0]         rej_q, rej_d;
  logic [2:0]         draw_ball_q, draw_ball_d;
  logic [2:0][2:0]    decoy_q, decoy_d;
  logic [2:0]         ball_color_q, ball_color_d;
  logic [3:0][2:0]    plat_colors_q, plat_colors_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         streak_q, streak_d;

  logic [15:0]        lfsr_step;
  logic [2:0]         d_draw;
  logic               draw_ok;
  logic [2:0]         fallback;
  logic [3:0][2:0]    placed;
  logic               store;
  logic [2:0]         store_val;
`ifdef DISTINCT_DECOYS_EN
  logic [2:0]         cand;
  logic               cand_used;
  logic               found;
`endif

  // Colour successor (c % 7) + 1, walking 1..7 cyclically.
  function automatic logic [2:0] next_col(input logic [2:0] c);
    return (c == 3'd7) ? 3'd1 : c + 3'd1;
  endfunction

  assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign d_draw    = lfsr_q[2:0];

  // Decide whether the current draw may fill the slot being generated.
  always_comb begin
    draw_ok = 1'b0;
    if (d_draw != 3'd0) begin
      if (idx_q == 2'd0) begin
        draw_ok = 1'b1;
      end else begin
        draw_ok = (d_draw != draw_ball_q);
`ifdef DISTINCT_DECOYS_EN
        if ((idx_q >= 2'd2) && (d_draw == decoy_q[0])) draw_ok = 1'b0;
        if ((idx_q == 2'd3) && (d_draw == decoy_q[1])) draw_ok = 1'b0;
`endif
      end
    end
  end

  // Colour forced in when too many draws in a row were rejected.
  always_comb begin
    fallback = 3'd7;
`ifdef DISTINCT_DECOYS_EN
    cand      = next_col(draw_ball_q);
    cand_used = 1'b0;
    found     = 1'b0;
`endif
    if (idx_q != 2'd0) begin
`ifdef DISTINCT_DECOYS_EN
      for (int n = 0; n < 6; n++) begin
        cand_used = (cand == draw_ball_q) ||
                    ((idx_q >= 2'd2) && (cand == decoy_q[0])) ||
                    ((idx_q == 2'd3) && (cand == decoy_q[1]));
        if (!found && !cand_used) begin
          fallback = cand;
          found    = 1'b1;
        end
        cand = next_col(cand);
      end
`else
      fallback = next_col(draw_ball_q);
`endif
    end
  end

  // Ball goes to slot lfsr[1:0]; decoys fill the other slots in ascending order.
  always_comb begin
    case (lfsr_q[1:0])
      2'd0:    placed = {decoy_q[2], decoy_q[1], decoy_q[0], draw_ball_q};
      2'd1:    placed = {decoy_q[2], decoy_q[1], draw_ball_q, decoy_q[0]};
      2'd2:    placed = {decoy_q[2], draw_ball_q, decoy_q[1], decoy_q[0]};
      default: placed = {draw_ball_q, decoy_q[2], decoy_q[1], decoy_q[0]};
    endcase
  end

  // Round sequencing: draw, place, wait for the landing, then score it.
  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q;
    idx_d         = idx_q;
    rej_d         = rej_q;
    draw_ball_d   = draw_ball_q;
    decoy_d       = decoy_q;
    ball_color_d  = ball_color_q;
    plat_colors_d = plat_colors_q;
    hit_d         = 1'b0;
    miss_d        = 1'b0;
    score_d       = score_q;
    streak_d      = streak_q;
    store         = 1'b0;
    store_val     = d_draw;

    case (state_q)
      S_IDLE: begin
        idx_d = 2'd0;
        rej_d = 4'd0;
        if (bus.start_round) state_d = S_GEN;
      end

      S_GEN: begin
        lfsr_d = lfsr_step;
        if (draw_ok) begin
          store = 1'b1;
        end else if ((rej_q + 4'd1) == MAX_DRAWS_C) begin
          store     = 1'b1;
          store_val = fallback;
        end else begin
          rej_d = rej_q + 4'd1;
        end
        if (store) begin
          rej_d = 4'd0;
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0:    draw_ball_d = store_val;
            2'd1:    decoy_d[0]  = store_val;
            2'd2:    decoy_d[1]  = store_val;
            default: decoy_d[2]  = store_val;
          endcase
          if (idx_q == 2'd3) state_d = S_PLACE;
        end
      end

      S_PLACE: begin
        lfsr_d        = lfsr_step;
        ball_color_d  = draw_ball_q;
        plat_colors_d = placed;
        state_d       = S_READY;
      end

      S_READY: begin
        if (bus.landed) begin
          state_d = S_IDLE;
          if (plat_colors_q[bus.landed_plat] == ball_color_q) begin
            hit_d = 1'b1;
            if (score_q != SCORE_MAX) score_d = score_q + SCORE_W'(1);
            if (streak_q != 4'hF) streak_d = streak_q + 4'd1;
          end else begin
            miss_d   = 1'b1;
            streak_d = 4'd0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any round in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      lfsr_q        <= SEED_EFF;
      idx_q         <= 2'd0;
      rej_q         <= 4'd0;
      draw_ball_q   <= 3'd0;
      decoy_q       <= '0;
      ball_color_q  <= 3'd0;
      plat_colors_q <= '0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
      score_q       <= '0;
      streak_q      <= 4'd0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      idx_q         <= idx_d;
      rej_q         <= rej_d;
      draw_ball_q   <= draw_ball_d;
      decoy_q       <= decoy_d;
      ball_color_q  <= ball_color_d;
      plat_colors_q <= plat_colors_d;
      hit_q         <= hit_d;
      miss_q        <= miss_d;
      score_q       <= score_d;
      streak_q      <= streak_d;
    end
  end

  assign bus.busy         = (state_q == S_GEN) || (state_q == S_PLACE);
  assign bus.colors_valid = (state_q == S_READY);
  assign bus.ball_color   = ball_color_q;
  assign bus.plat_colors  = plat_colors_q;
  assign bus.hit          = hit_q;
  assign bus.miss         = miss_q;
  assign bus.score        = score_q;
  assign bus.streak       = streak_q;

endmodule
